// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handoff and redirect.
interface fetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output instr_valid, instruction, instr_pc,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  instr_valid, instruction, instr_pc,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding 64-bit read, split into two 32-bit instructions,
// buffered in a small FIFO towards decode; a redirect flushes buffered and in-flight work.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  fif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FLUSH} state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } entry_t;

  state_e             state_q, state_d;
  logic [63:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             buf_q [DEPTH];

  logic               we0, we1;
  entry_t             wd0, wd1;
  logic               req_fire, pop, room;
  logic               unused_rpc_lsb;

  assign req_fire = (state_q == S_REQ) && fif.mem_req_ready;
  assign pop      = (count_q != '0) && fif.instr_ready;
  // A same-cycle pop is not counted as freed space.
  assign room     = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);
  assign unused_rpc_lsb = ^fif.redirect_pc[1:0];

  // Next-state, fetch PC and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    we0        = 1'b0;
    we1        = 1'b0;
    wd0        = '0;
    wd1        = '0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE:  if (room) state_d = S_REQ;
      S_REQ:   if (req_fire) state_d = S_RESP;
      S_RESP: begin
        if (fif.mem_resp_valid) begin
          state_d = S_IDLE;
          we0     = 1'b1;
          if (!fetch_pc_q[2]) begin
            wd0        = '{pc: fetch_pc_q, insn: fif.mem_resp_data[31:0]};
            we1        = 1'b1;
            wd1        = '{pc: fetch_pc_q + 64'd4, insn: fif.mem_resp_data[63:32]};
            fetch_pc_d = fetch_pc_q + 64'd8;
          end else begin
            wd0        = '{pc: fetch_pc_q, insn: fif.mem_resp_data[63:32]};
            fetch_pc_d = fetch_pc_q + 64'd4;
          end
        end
      end
      S_FLUSH: if (fif.mem_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    wr_ptr_d = wr_ptr_q + PTR_W'(we0) + PTR_W'(we1);
    count_d  = count_q + CNT_W'(we0) + CNT_W'(we1) - CNT_W'(pop);

    // Redirect overrides everything: empty the buffer and track the one in-flight response.
    if (fif.redirect_valid) begin
      fetch_pc_d = {fif.redirect_pc[63:2], 2'b00};
      we0        = 1'b0;
      we1        = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      case (state_q)
        S_REQ:   state_d = req_fire ? S_FLUSH : S_IDLE;
        S_RESP,
        S_FLUSH: state_d = fif.mem_resp_valid ? S_IDLE : S_FLUSH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      buf_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (we0) buf_q[wr_ptr_q] <= wd0;
      if (we1) buf_q[wr_ptr_q + PTR_W'(1)] <= wd1;
    end
  end

  assign fif.mem_req_valid = (state_q == S_REQ);
  assign fif.mem_req_addr  = (state_q == S_REQ) ? {fetch_pc_q[63:3], 3'b000} : 64'd0;
  assign fif.instr_valid   = (count_q != '0);
  assign fif.instruction   = buf_q[rd_ptr_q].insn;
  assign fif.instr_pc      = buf_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction-memory model.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam logic [31:0] KEY    = 32'h1300_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat      = 1;
  int          pend     = 0;
  int          n_req    = 0;
  logic [63:0] pend_data;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h1000) return 64'h00a00093_00500113;
    return {32'(a + 64'd4) ^ KEY, 32'(a) ^ KEY};
  endfunction

  function automatic logic [31:0] exp_insn(input logic [63:0] pc);
    case (pc)
      64'h1000: return 32'h00500113;
      64'h1004: return 32'h00a00093;
      default:  return pc[31:0] ^ KEY;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory: handshake seen before a posedge returns data 'lat' cycles later.
  always @(negedge clk) begin
    bus.mem_resp_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = pend_data;
      end
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      pend      = lat;
      pend_data = mem_word(bus.mem_req_addr);
      n_req++;
    end
  end

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [63:0] addr);
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_req_valid) break;
      tick();
    end
    chk({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    chk({tag, "_req_addr"}, bus.mem_req_addr, addr);
  endtask

  task automatic expect_instr(input string tag, input logic [63:0] pc);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.instr_valid) break;
    end
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    chk({tag, "_insn"}, 64'(bus.instruction), 64'(exp_insn(pc)));
    chk({tag, "_pc"}, bus.instr_pc, pc);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, 64'd0);
    chk({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'd0);
    chk({tag, "_insn"}, 64'(bus.instruction), 64'd0);
    chk({tag, "_instr_pc"}, bus.instr_pc, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset              = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset state, then basic two-instruction fetch
    tick();
    tick();
    chk_outputs_zero("rst");
    reset = 1'b0;
    wait_req("t1a", 64'h1000);
    expect_instr("t1i0", 64'h1000);
    expect_instr("t1i1", 64'h1004);
    wait_req("t1b", 64'h1008);

    // Redirect to an odd word while idle
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2004;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t2_idle_req", 64'(bus.mem_req_valid), 64'd0);
    wait_req("t2a", 64'h2000);
    expect_instr("t2i", 64'h2004);
    wait_req("t2b", 64'h2008);

    // Back-pressure fills the buffer and stalls fetch
    bus.instr_ready = 1'b0;
    do_reset();
    base = n_req;
    for (int i = 0; i < 12; i++) tick();
    chk("t3_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("t3_nreq", 64'(n_req - base), 64'd2);
    chk("t3_instr_valid", 64'(bus.instr_valid), 64'd1);
    chk("t3_head_pc", bus.instr_pc, 64'h1000);
    chk("t3_head_insn", 64'(bus.instruction), 64'h00500113);
    bus.instr_ready = 1'b1;
    expect_instr("t3i1", 64'h1004);
    expect_instr("t3i2", 64'h1008);
    expect_instr("t3i3", 64'h100C);
    wait_req("t3r", 64'h1010);
    expect_instr("t3i4", 64'h1010);

    // Redirect in RESP; stale response arrives two cycles later
    do_reset();
    lat = 3;
    wait_req("t4a", 64'h1000);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3000;
    lat = 1;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t4_iv0", 64'(bus.instr_valid), 64'd0);
    chk("t4_rv0", 64'(bus.mem_req_valid), 64'd0);
    tick();
    chk("t4_rv1", 64'(bus.mem_req_valid), 64'd0);
    tick();
    chk("t4_iv2", 64'(bus.instr_valid), 64'd0);
    wait_req("t4b", 64'h3000);
    expect_instr("t4i0", 64'h3000);
    expect_instr("t4i1", 64'h3004);

    // Redirect coinciding with response and pop
    bus.instr_ready = 1'b0;
    do_reset();
    wait_req("t5a", 64'h1000);
    tick();
    wait_req("t5b", 64'h1008);
    tick();
    chk("t5_iv_pre", 64'(bus.instr_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h4000;
    bus.instr_ready    = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_iv_post", 64'(bus.instr_valid), 64'd0);
    chk("t5_rv_post", 64'(bus.mem_req_valid), 64'd0);
    wait_req("t5c", 64'h4000);
    expect_instr("t5i", 64'h4000);

    // Stalled request stays stable; reset mid-stall
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h5000;
    tick();
    bus.redirect_valid = 1'b0;
    wait_req("t6a", 64'h5000);
    tick();
    bus.mem_req_ready = 1'b0;
    wait_req("t6b", 64'h5008);
    chk("t6_head_pc", bus.instr_pc, 64'h5000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t6_hold_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("t6_hold_addr", bus.mem_req_addr, 64'h5008);
    end
    reset = 1'b1;
    tick();
    chk_outputs_zero("t6rst");
    reset = 1'b0;
    bus.mem_req_ready = 1'b1;
    wait_req("t6c", RST_PC);

    // Redirect with handshake; PC wraps past 2^64, low redirect bits ignored
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t7_rv_post", 64'(bus.mem_req_valid), 64'd0);
    wait_req("t7a", 64'hFFFF_FFFF_FFFF_FFF8);
    expect_instr("t7i", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("t7b", 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
